// File: rtl/cluster_periph_demux.sv
// Cluster peripheral demux: one master port fanned out to NB_SLAVES slaves by address index, in-order tagged responses.
// Optional response timeout with sticky dead-slave flags when CLUSTER_PERIPH_TIMEOUT_EN is defined.

// Order FIFO: head visible combinationally; push is dropped when full, pop when empty.
module cluster_periph_demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok, pop_ok;

  assign head_vld = (cnt != '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign head_dat = mem[rd_ptr];
  assign push_ok  = push_vld & ~full;
  assign pop_ok   = pop_rdy & head_vld;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop_ok) cnt <= cnt - 1'b1;
    end
  end
endmodule

module cluster_periph_demux #(
  parameter int                   NB_SLAVES       = 10,
  parameter int                   ADDR_LSB        = 10,
  parameter int                   ID_WIDTH        = 5,
  parameter int                   MAX_OUTSTANDING = 4,
  parameter logic [NB_SLAVES-1:0] SLAVE_EN_MASK   = 10'h3F7,
  parameter logic [31:0]          ERR_RDATA       = 32'hBADACCE5,
  parameter int                   TIMEOUT_CYCLES  = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         wdata_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [31:0]         r_rdata_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [NB_SLAVES-1:0] s_req_o,
  output logic [31:0]         s_add_o   [NB_SLAVES],
  output logic [NB_SLAVES-1:0] s_wen_o,
  output logic [3:0]          s_be_o    [NB_SLAVES],
  output logic [31:0]         s_wdata_o [NB_SLAVES],
  output logic [ID_WIDTH-1:0] s_id_o    [NB_SLAVES],
  input  logic [NB_SLAVES-1:0] s_gnt_i,
  input  logic [NB_SLAVES-1:0] s_r_valid_i,
  input  logic [NB_SLAVES-1:0] s_r_opc_i,
  input  logic [31:0]         s_r_rdata_i [NB_SLAVES],
  output logic                timeout_o,
  output logic [NB_SLAVES-1:0] dead_o
);
  localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

  if (MAX_OUTSTANDING < 1) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic                err;
    logic [ID_WIDTH-1:0] id;
  } ord_t;

  ord_t                 push_ent, head;
  logic [IDX_W-1:0]     idx;
  logic                 mapped, sel_gnt, full, head_vld, head_wait;
  logic                 head_rsp, head_opc, pop, to_hit;
  logic [31:0]          head_rdata;
  logic [NB_SLAVES-1:0] exp_rsp;

  assign idx = add_i[ADDR_LSB +: IDX_W];

  // Out-of-range indices never match a loop index, so they fall through to the error path.
  always_comb begin
    mapped  = 1'b0;
    sel_gnt = 1'b0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        mapped  = SLAVE_EN_MASK[i] & ~dead_o[i];
        sel_gnt = s_gnt_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NB_SLAVES; i++) begin
      s_req_o[i]   = req_i & mapped & ~full & (idx == IDX_W'(i));
      s_add_o[i]   = add_i;
      s_wen_o[i]   = wen_i;
      s_be_o[i]    = be_i;
      s_wdata_o[i] = wdata_i;
      s_id_o[i]    = id_i;
    end
  end

  assign gnt_o    = req_i & ~full & (mapped ? sel_gnt : 1'b1);
  assign push_ent = {idx, ~mapped, id_i};

  cluster_periph_demux_fifo #(
    .WIDTH ($bits(ord_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (gnt_o),
    .push_dat (push_ent),
    .pop_rdy  (pop),
    .head_vld (head_vld),
    .head_dat (head),
    .full     (full)
  );

  assign head_wait = head_vld & ~head.err;

  always_comb begin
    head_rsp   = 1'b0;
    head_opc   = 1'b0;
    head_rdata = '0;
    exp_rsp    = '0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (head.idx == IDX_W'(i)) begin
        head_rsp   = head_wait & s_r_valid_i[i] & ~dead_o[i];
        head_opc   = s_r_opc_i[i];
        head_rdata = s_r_rdata_i[i];
        exp_rsp[i] = head_wait;
      end
    end
  end

  assign pop = head_vld & (head.err | head_rsp | to_hit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_opc_o   <= 1'b0;
      r_rdata_o <= '0;
      r_id_o    <= '0;
    end else begin
      r_valid_o <= pop;
      if (pop) begin
        r_id_o <= head.id;
        if (head_rsp) begin
          r_opc_o   <= head_opc;
          r_rdata_o <= head_rdata;
        end else begin
          r_opc_o   <= 1'b1;
          r_rdata_o <= ERR_RDATA;
        end
      end
    end
  end

`ifdef CLUSTER_PERIPH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // A real response in the expiry cycle takes priority over the timeout.
  assign to_hit = head_wait & ~head_rsp & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
      dead_o    <= '0;
    end else begin
      timeout_o <= to_hit;
      if (pop)            to_cnt <= '0;
      else if (head_wait) to_cnt <= to_cnt + 1'b1;
      if (to_hit) dead_o <= dead_o | exp_rsp;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
  assign dead_o    = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(|(s_r_valid_i & ~dead_o & ~exp_rsp)))
        else $error("response from a slave that is not at the head of the order FIFO");
    end
  end
`endif
endmodule
